sel_scanner: RTL and testbench
==============================

# sel_scanner

Channel-select sequencer that sits directly upstream of the `binary_to_onehot` decoder in the Schmitt playground. It produces the registered binary select `sel` plus a `sel_valid` qualifier. The select is either held at a host-loaded value or auto-stepped through all channels with a programmable dwell. A one-cycle break-before-make blank is inserted on every select change, so downstream analog switches never see two channels enabled.

## Interface
- `SEL_WIDTH`, 4: width of `sel`; channel count is 2**SEL_WIDTH.
- `DWELL_WIDTH`, 8: width of the dwell counter and the `dwell` input.
- `clk`  in  1  system clock; all state changes on its rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `ena`  in  1  clock enable. Low freezes all state and outputs; `step`/`wrap` are forced to 0 while low.
- `mode_scan`  in  1  1 = auto-scan, 0 = hold.
- `load`  in  1  single-cycle request to load `load_sel`.
- `load_sel`  in  SEL_WIDTH  channel to load.
- `dwell`  in  DWELL_WIDTH  valid-cycles-minus-one per channel in scan; sampled on each BLANK exit.
- `sel`  out  SEL_WIDTH  registered channel select to the decoder.
- `sel_valid`  out  1  registered; 0 during BLANK, meaning the decoder output must be ignored or gated.
- `step`  out  1  one-cycle pulse coincident with every `sel` change.
- `wrap`  out  1  one-cycle pulse when scan passes the end of range.

## Operation
- States: HOLD, SCAN, BLANK (enum in package).
- Reset values: state=BLANK, `sel`=0, `sel_valid`=0, `step`=0, `wrap`=0, counter=0, `dwell_q`=0.
- BLANK (one cycle, with `ena` high):
  - next state = SCAN if `mode_scan` is 1, else HOLD.
  - `sel_valid`←1, counter←0, `dwell_q`←`dwell`.
- HOLD: `sel` is constant and `sel_valid`=1. If `mode_scan` rises, go to SCAN with counter←0 and `dwell_q`←`dwell`; there is no blank because `sel` is unchanged.
- SCAN:
  - counter increments each enabled cycle.
  - When counter==`dwell_q`: `sel`←next, `step`←1, `wrap`←(end of range), `sel_valid`←0, state←BLANK.
  - If `mode_scan` falls, go to HOLD on the next edge. `sel` is kept, `sel_valid` stays 1, and no step occurs.
- Next select, default: `sel`+1 modulo 2**SEL_WIDTH. `wrap` is set when `sel` was all-ones.
- `load` has priority over everything, in any state: `sel`←`load_sel`, state←BLANK, `sel_valid`←0, `step`←1, `wrap`←0, counter←0.
  - `load` with `load_sel`==`sel` still blanks and steps.
- `load` while `ena` is low is ignored and not latched.
- `step` and `wrap` are high for exactly one cycle; a cycle with no step drives them to 0.
- Async reset mid-scan returns all outputs to their reset values immediately. First valid `sel`=0 appears one enabled edge after release.

## Timing
- All outputs are registered; no combinational input-to-output paths.
- Load sampled at edge N → `sel`=`load_sel` and `sel_valid`=0 after N; `sel_valid`=1 after N+1.
- Scan period = `dwell`+2 enabled cycles: `dwell`+1 valid cycles plus 1 BLANK cycle.
  - `dwell`=0 gives 1 valid and 1 blank cycle, alternating.
- `dwell` changes take effect at the next BLANK exit, never mid-channel.
- Counter width is DWELL_WIDTH and compared for equality, so counter never overflows.

## Configuration
- `SEL_SCANNER_PINGPONG_EN` defined:
  - Scan direction reverses at the range ends: 0,1,…,max,max-1,…,0,1,…
  - `wrap` pulses on each turnaround step (the step away from max or from 0).
  - `load` keeps the current direction.
  - Reset direction is up.
- `SEL_SCANNER_PINGPONG_EN` undefined: modulo increment only, no direction register.

## Structure
- `sel_scanner_pkg`: state enum typedef (HOLD, SCAN, BLANK) and the localparam for the all-ones end-of-range.
- One sub-module, `dwell_timer`: DWELL_WIDTH counter with clear, enable and an `expired` (count==limit) flag.
- `sel_scanner` owns the FSM, the `sel` register and the pulse generation.

## Test plan
- Reset, then `ena`=1, `mode_scan`=0 → after reset `sel`=0 and `sel_valid`=0; one edge later `sel_valid`=1; stays in HOLD indefinitely with no `step`.
- `mode_scan`=1, `dwell`=3, SEL_WIDTH=4 → `sel` advances every 5 cycles with `sel_valid` low 1 cycle per step; `wrap` pulses exactly once on 15→0 after 80 cycles.
- Scanning at `sel`=6, assert `load` with `load_sel`=2 mid-dwell → next cycle `sel`=2, `step`=1, `sel_valid`=0; then 4 valid cycles at 2 before 3.
- `ena` low for 10 cycles mid-dwell, with `load` pulsed while low → counter, `sel` and `sel_valid` frozen; load ignored; the step occurs exactly 10 cycles late.
- `dwell`=0 scan, then drop `mode_scan` while in SCAN → alternating valid/blank cycles; HOLD on the current `sel` with `sel_valid`=1 and no further steps.
- With `SEL_SCANNER_PINGPONG_EN`, `dwell`=0 → `sel` sequence 14,15,14,…,1,0,1; `wrap` pulses on the steps 15→14 and 0→1.

Source files
------------

// File: rtl/sel_scanner_pkg.sv
// sel_scanner_pkg: shared types and constants for the channel-select sequencer.
// FSM state encoding plus default widths and the end-of-range helper.
package sel_scanner_pkg;

    typedef enum logic [1:0] {
        HOLD  = 2'd0,
        SCAN  = 2'd1,
        BLANK = 2'd2
    } state_t;

    localparam int unsigned SEL_WIDTH_DFLT   = 4;
    localparam int unsigned DWELL_WIDTH_DFLT = 8;

    // All-ones end-of-range select for the default select width.
    localparam logic [SEL_WIDTH_DFLT-1:0] SEL_END_DFLT = '1;

    // All-ones end-of-range value for an arbitrary select width (w < 32).
    function automatic logic [31:0] sel_end(input int unsigned w);
        return (32'd1 << w) - 32'd1;
    endfunction

endpackage

// File: rtl/dwell_timer.sv
// dwell_timer: up-counter with synchronous clear and enable. expired is high
// while the count equals the limit; the owner stops counting at that point,
// so the counter never needs to wrap.
module dwell_timer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             en,
    input  logic [WIDTH-1:0] limit,
    output logic             expired
);

    logic [WIDTH-1:0] count;

    // Count register: clear wins over enable.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en) begin
            count <= count + 1'b1;
        end
    end

    assign expired = (count == limit);

endmodule

// File: rtl/sel_scanner.sv
// sel_scanner: channel-select sequencer feeding the binary_to_onehot decoder.
// Holds a host-loaded select or auto-steps through all channels with a
// programmable dwell, inserting a one-cycle break-before-make blank on every
// select change.
// Optional build macro: SEL_SCANNER_PINGPONG_EN (bounce between range ends
// instead of wrapping modulo).
//
//   state | meaning
//   ------+-------------------------------------------------------------
//   HOLD  | sel fixed, sel_valid=1, waiting for mode_scan or load
//   SCAN  | sel valid, dwell timer counting toward dwell_q
//   BLANK | one cycle after any sel change, sel_valid=0
module sel_scanner
    import sel_scanner_pkg::*;
#(
    parameter int SEL_WIDTH   = SEL_WIDTH_DFLT,
    parameter int DWELL_WIDTH = DWELL_WIDTH_DFLT
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   ena,
    input  logic                   mode_scan,
    input  logic                   load,
    input  logic [SEL_WIDTH-1:0]   load_sel,
    input  logic [DWELL_WIDTH-1:0] dwell,
    output logic [SEL_WIDTH-1:0]   sel,
    output logic                   sel_valid,
    output logic                   step,
    output logic                   wrap
);

    localparam logic [SEL_WIDTH-1:0] SEL_LAST = SEL_WIDTH'(sel_end(SEL_WIDTH));

    state_t                 state, state_d;
    logic [SEL_WIDTH-1:0]   sel_d, sel_next;
    logic                   sel_valid_d, step_d, wrap_d, wrap_next;
    logic [DWELL_WIDTH-1:0] dwell_q, dwell_q_d;
    logic                   tmr_clr, tmr_en, expired;

`ifdef SEL_SCANNER_PINGPONG_EN
    logic dir_up, dir_up_d, dir_up_next;

    // Next channel when bouncing: reverse at either end and flag the turnaround.
    always_comb begin
        sel_next    = sel;
        wrap_next   = 1'b0;
        dir_up_next = dir_up;
        if (dir_up) begin
            if (sel == SEL_LAST) begin
                sel_next    = sel - 1'b1;
                wrap_next   = 1'b1;
                dir_up_next = 1'b0;
            end else begin
                sel_next = sel + 1'b1;
            end
        end else begin
            if (sel == '0) begin
                sel_next    = sel + 1'b1;
                wrap_next   = 1'b1;
                dir_up_next = 1'b1;
            end else begin
                sel_next = sel - 1'b1;
            end
        end
    end

    // Direction register; resets to counting up.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dir_up <= 1'b1;
        end else begin
            dir_up <= dir_up_d;
        end
    end
`else
    // Next channel: modulo increment, wrap flagged when leaving the last channel.
    always_comb begin
        sel_next  = sel + 1'b1;
        wrap_next = (sel == SEL_LAST);
    end
`endif

    dwell_timer #(
        .WIDTH (DWELL_WIDTH)
    ) u_dwell_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (tmr_clr),
        .en      (tmr_en),
        .limit   (dwell_q),
        .expired (expired)
    );

    // Next-state and next-output decode; load beats everything, ena low freezes.
    always_comb begin
        state_d     = state;
        sel_d       = sel;
        sel_valid_d = sel_valid;
        step_d      = 1'b0;
        wrap_d      = 1'b0;
        dwell_q_d   = dwell_q;
        tmr_clr     = 1'b0;
        tmr_en      = 1'b0;
`ifdef SEL_SCANNER_PINGPONG_EN
        dir_up_d    = dir_up;
`endif
        if (!ena) begin
            // frozen: only the pulses drop
        end else if (load) begin
            sel_d       = load_sel;
            state_d     = BLANK;
            sel_valid_d = 1'b0;
            step_d      = 1'b1;
            tmr_clr     = 1'b1;
        end else begin
            case (state)
                BLANK: begin
                    state_d     = mode_scan ? SCAN : HOLD;
                    sel_valid_d = 1'b1;
                    tmr_clr     = 1'b1;
                    dwell_q_d   = dwell;
                end
                HOLD: begin
                    sel_valid_d = 1'b1;
                    if (mode_scan) begin
                        // sel unchanged, so no blank is needed
                        state_d   = SCAN;
                        tmr_clr   = 1'b1;
                        dwell_q_d = dwell;
                    end
                end
                SCAN: begin
                    if (!mode_scan) begin
                        state_d = HOLD;
                    end else if (expired) begin
                        sel_d       = sel_next;
                        step_d      = 1'b1;
                        wrap_d      = wrap_next;
                        sel_valid_d = 1'b0;
                        state_d     = BLANK;
`ifdef SEL_SCANNER_PINGPONG_EN
                        dir_up_d    = dir_up_next;
`endif
                    end else begin
                        tmr_en = 1'b1;
                    end
                end
                default: begin
                    state_d     = BLANK;
                    sel_valid_d = 1'b0;
                end
            endcase
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= BLANK;
        end else begin
            state <= state_d;
        end
    end

    // Registered outputs and latched dwell.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel       <= '0;
            sel_valid <= 1'b0;
            step      <= 1'b0;
            wrap      <= 1'b0;
            dwell_q   <= '0;
        end else begin
            sel       <= sel_d;
            sel_valid <= sel_valid_d;
            step      <= step_d;
            wrap      <= wrap_d;
            dwell_q   <= dwell_q_d;
        end
    end

endmodule

// File: tb/tb_sel_scanner.sv
// tb_sel_scanner: directed bench for sel_scanner with hand-computed expectations.
// Covers both the default build and SEL_SCANNER_PINGPONG_EN.
module tb_sel_scanner;

    localparam int SW = 4;
    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rst_n, ena, mode_scan, load;
    logic [SW-1:0] load_sel;
    logic [DW-1:0] dwell;
    logic [SW-1:0] sel;
    logic          sel_valid, step, wrap;

    int n_vec  = 0;
    int n_miss = 0;
    int wraps;
    int prev_sel;
    int e_sel;

`ifdef SEL_SCANNER_PINGPONG_EN
    int seq_sel[17]  = '{15, 14, 13, 12, 11, 10, 9, 8, 7, 6, 5, 4, 3, 2, 1, 0, 1};
    int seq_wrap[17] = '{0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1};
`else
    int seq_sel[3]   = '{15, 0, 1};
    int seq_wrap[3]  = '{0, 1, 0};
`endif

    always #5 clk = ~clk;

    sel_scanner #(
        .SEL_WIDTH   (SW),
        .DWELL_WIDTH (DW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ena       (ena),
        .mode_scan (mode_scan),
        .load      (load),
        .load_sel  (load_sel),
        .dwell     (dwell),
        .sel       (sel),
        .sel_valid (sel_valid),
        .step      (step),
        .wrap      (wrap)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check_val(input string tag, input int obs, input int exp);
        n_vec++;
        if (obs != exp) begin
            n_miss++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic check_outs(input string tag, input int e_s, input int e_v,
                              input int e_st, input int e_w);
        check_val({tag, ".sel"},       int'(sel),       e_s);
        check_val({tag, ".sel_valid"}, int'(sel_valid), e_v);
        check_val({tag, ".step"},      int'(step),      e_st);
        check_val({tag, ".wrap"},      int'(wrap),      e_w);
    endtask

    initial begin
        rst_n     = 1'b0;
        ena       = 1'b1;
        mode_scan = 1'b0;
        load      = 1'b0;
        load_sel  = '0;
        dwell     = 8'd3;
        repeat (2) @(negedge clk);
        check_outs("reset", 0, 0, 0, 0);
        rst_n = 1'b1;

        // first edge leaves BLANK into HOLD
        tick;
        check_outs("first_valid", 0, 1, 0, 0);
        for (int i = 0; i < 20; i++) begin
            tick;
            check_outs("hold", 0, 1, 0, 0);
        end

        // scan, dwell=3: step every 5 edges, first one on edge 5
        mode_scan = 1'b1;
        for (int t = 1; t <= 32; t++) begin
            tick;
            check_outs("scan", t / 5, (t % 5 == 0) ? 0 : 1, (t % 5 == 0) ? 1 : 0, 0);
        end

        // mid-dwell at sel=6, load 2
        load     = 1'b1;
        load_sel = 4'd2;
        tick;
        check_outs("load", 2, 0, 1, 0);
        load = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick;
            check_outs("load_dwell", 2, 1, 0, 0);
        end
        tick;
        check_outs("load_next", 3, 0, 1, 0);

        // freeze mid-dwell for 10 cycles with a load pulse while frozen
        tick;
        check_outs("pre_freeze0", 3, 1, 0, 0);
        tick;
        check_outs("pre_freeze1", 3, 1, 0, 0);
        ena      = 1'b0;
        load_sel = 4'd9;
        for (int i = 0; i < 10; i++) begin
            load = (i == 3);
            tick;
            check_outs("freeze", 3, 1, 0, 0);
        end
        load = 1'b0;
        ena  = 1'b1;
        tick;
        check_outs("thaw0", 3, 1, 0, 0);
        tick;
        check_outs("thaw1", 3, 1, 0, 0);
        tick;
        check_outs("late_step", 4, 0, 1, 0);

        // dwell=0 takes effect at the next BLANK exit, then drop mode_scan
        dwell = 8'd0;
        tick;
        check_outs("d0_valid4", 4, 1, 0, 0);
        tick;
        check_outs("d0_step5", 5, 0, 1, 0);
        tick;
        check_outs("d0_valid5", 5, 1, 0, 0);
        tick;
        check_outs("d0_step6", 6, 0, 1, 0);
        tick;
        check_outs("d0_valid6", 6, 1, 0, 0);
        mode_scan = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick;
            check_outs("hold_drop", 6, 1, 0, 0);
        end

        // load of the current channel still blanks and steps
        load     = 1'b1;
        load_sel = 4'd6;
        tick;
        check_outs("load_same", 6, 0, 1, 0);
        load = 1'b0;
        tick;
        check_outs("load_same_v0", 6, 1, 0, 0);
        tick;
        check_outs("load_same_v1", 6, 1, 0, 0);

        // async reset mid-scan, then a full 80-edge pass from channel 0
        mode_scan = 1'b1;
        dwell     = 8'd3;
        tick;
        check_outs("rescan0", 6, 1, 0, 0);
        tick;
        check_outs("rescan1", 6, 1, 0, 0);
        #2;
        rst_n = 1'b0;
        #1;
        check_outs("async_rst", 0, 0, 0, 0);
        @(negedge clk);
        rst_n = 1'b1;
        wraps = 0;
        for (int t = 1; t <= 80; t++) begin
            tick;
            e_sel = (t / 5) % 16;
`ifdef SEL_SCANNER_PINGPONG_EN
            if (t == 80) e_sel = 14;
`endif
            check_outs("scan80", e_sel, (t % 5 == 0) ? 0 : 1, (t % 5 == 0) ? 1 : 0,
                       (t == 80) ? 1 : 0);
            wraps += int'(wrap);
        end
        check_val("wrap_count", wraps, 1);

        // dwell=0 run from 14 across the end of range (fresh reset: direction up)
        rst_n = 1'b0;
        #1;
        @(negedge clk);
        rst_n     = 1'b1;
        dwell     = 8'd0;
        mode_scan = 1'b1;
        load      = 1'b1;
        load_sel  = 4'd14;
        tick;
        check_outs("end_load", 14, 0, 1, 0);
        load     = 1'b0;
        prev_sel = 14;
        foreach (seq_sel[i]) begin
            tick;
            check_outs("end_valid", prev_sel, 1, 0, 0);
            tick;
            check_outs("end_step", seq_sel[i], 0, 1, seq_wrap[i]);
            prev_sel = seq_sel[i];
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
